// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm scheduler: FSM states, report
// severity encoding and the saturating error-count helper.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic       SEV_WARN = 1'b0;
  localparam logic       SEV_ERR  = 1'b1;
  localparam logic [7:0] CNT_SAT  = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == CNT_SAT) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit strictly after
// `last`, wrapping modulo h.
module rr_pick
  import alarm_pkg::*;
#(
  parameter  int h = 8,
  localparam int W = $clog2(h)
) (
  input  logic [h-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W-1:0] probe;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    found = 1'b0;
    idx   = '0;
    probe = '0;
    for (int k = 1; k <= h; k++) begin
      probe = W'((int'(last) + k) % h);
      if (!found && req[probe]) begin
        found = 1'b1;
        idx   = probe;
      end
    end
  end

endmodule

// File: rtl/alarm_scheduler.sv
// Latches detector warning/error edges, offers one report at a time with
// errors ranked first, and optionally pulses det_reset after an error report.
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter  int h          = 8,
  parameter  int FLUSH_CYC  = 4,
  parameter  bit AUTO_FLUSH = 1'b1,
  localparam int W          = $clog2(h)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [h-1:0] warning,
  input  logic [h-1:0] error,
  input  logic [h-1:0] mask,
  output logic         rep_valid,
  input  logic         rep_ready,
  output logic [W-1:0] rep_channel,
  output logic         rep_severity,
  output logic         det_reset,
  output logic [7:0]   err_count
);

  localparam int            CW         = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYC - 1);
  localparam logic [W-1:0]  LAST_INIT  = W'(h - 1);

  state_t        state, state_n;
  logic [h-1:0]  warn_q, err_q;
  logic [h-1:0]  pw, pw_n, pe, pe_n;
  logic [h-1:0]  rise_w, rise_e;
  logic [W-1:0]  cur_ch, cur_ch_n;
  logic          cur_sev, cur_sev_n;
  logic [W-1:0]  last, last_n;
  logic [CW-1:0] flush_cnt, flush_cnt_n;
  logic [7:0]    err_cnt, err_cnt_n;
  logic          found_w, found_e;
  logic [W-1:0]  idx_w, idx_e;

  assign rise_w = warning & ~warn_q & ~mask;
  assign rise_e = error   & ~err_q  & ~mask;

  rr_pick #(.h(h)) u_pick_err (
    .req   (pe),
    .last  (last),
    .found (found_e),
    .idx   (idx_e)
  );

  rr_pick #(.h(h)) u_pick_warn (
    .req   (pw),
    .last  (last),
    .found (found_w),
    .idx   (idx_w)
  );

  always_comb begin
    state_n     = state;
    pw_n        = pw;
    pe_n        = pe;
    cur_ch_n    = cur_ch;
    cur_sev_n   = cur_sev;
    last_n      = last;
    flush_cnt_n = flush_cnt;
    err_cnt_n   = err_cnt;

    case (state)
      IDLE: begin
        if (found_e) begin
          cur_ch_n  = idx_e;
          cur_sev_n = SEV_ERR;
          state_n   = OFFER;
        end else if (found_w) begin
          cur_ch_n  = idx_w;
          cur_sev_n = SEV_WARN;
          state_n   = OFFER;
        end
      end
      OFFER: begin
        if (rep_ready) begin
          // Any acceptance retires the channel's warning; errors also retire pe.
          pw_n[cur_ch] = 1'b0;
          if (cur_sev == SEV_ERR) begin
            pe_n[cur_ch] = 1'b0;
            err_cnt_n    = sat_inc(err_cnt);
          end
          last_n = cur_ch;
          if (cur_sev == SEV_ERR && AUTO_FLUSH) begin
            state_n     = FLUSH;
            flush_cnt_n = FLUSH_LOAD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt == '0) state_n = IDLE;
        else                 flush_cnt_n = flush_cnt - CW'(1);
      end
      default: state_n = IDLE;
    endcase

    // Masking clears pending work; a fresh edge overrides any clear this cycle.
    pw_n = (pw_n & ~mask) | rise_w;
    pe_n = (pe_n & ~mask) | rise_e;
  end

  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      warn_q    <= '0;
      err_q     <= '0;
      pw        <= '0;
      pe        <= '0;
      cur_ch    <= '0;
      cur_sev   <= SEV_WARN;
      last      <= LAST_INIT;
      flush_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      warn_q    <= warning;
      err_q     <= error;
      pw        <= pw_n;
      pe        <= pe_n;
      cur_ch    <= cur_ch_n;
      cur_sev   <= cur_sev_n;
      last      <= last_n;
      flush_cnt <= flush_cnt_n;
      err_cnt   <= err_cnt_n;
    end
  end

  assign rep_valid    = (state == OFFER);
  assign det_reset    = (state == FLUSH);
  assign rep_channel  = cur_ch;
  assign rep_severity = cur_sev;
  assign err_count    = err_cnt;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler: expected reports are queued as stimulus
// is driven and compared when the DUT hands them over.
module tb_alarm_scheduler;
  import alarm_pkg::*;

  typedef struct packed {
    logic [2:0] ch;
    logic       sev;
  } rep_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] warning, error, mask;
  logic       rep_ready;
  logic       rep_valid, rep_severity, det_reset;
  logic [2:0] rep_channel;
  logic [7:0] err_count;

  // Second instance with AUTO_FLUSH=0 for round-robin and saturation runs.
  logic [7:0] error_nf;
  logic       rep_ready_nf;
  logic       rep_valid_nf, rep_severity_nf, det_reset_nf;
  logic [2:0] rep_channel_nf;
  logic [7:0] err_count_nf;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   acc = 0, acc_nf = 0, dr = 0, dr_nf = 0;
  int   a0, d0;
  rep_t sb[$], sb_nf[$];
  rep_t exp_m, exp_nf;

  always #5 clock = ~clock;

  alarm_scheduler #(.h(8), .FLUSH_CYC(4), .AUTO_FLUSH(1'b1)) dut (
    .clock        (clock),
    .reset        (reset),
    .warning      (warning),
    .error        (error),
    .mask         (mask),
    .rep_valid    (rep_valid),
    .rep_ready    (rep_ready),
    .rep_channel  (rep_channel),
    .rep_severity (rep_severity),
    .det_reset    (det_reset),
    .err_count    (err_count)
  );

  alarm_scheduler #(.h(8), .FLUSH_CYC(4), .AUTO_FLUSH(1'b0)) dut_nf (
    .clock        (clock),
    .reset        (reset),
    .warning      (8'h00),
    .error        (error_nf),
    .mask         (8'h00),
    .rep_valid    (rep_valid_nf),
    .rep_ready    (rep_ready_nf),
    .rep_channel  (rep_channel_nf),
    .rep_severity (rep_severity_nf),
    .det_reset    (det_reset_nf),
    .err_count    (err_count_nf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain(input bit nf, input string tag);
    int budget = 300;
    while (((nf ? sb_nf.size() : sb.size()) != 0) && budget > 0) begin
      tick();
      budget--;
    end
    check(tag, 32'(nf ? sb_nf.size() : sb.size()), 0);
    tick(2);
  endtask

  // Scoreboard side: a handshake seen before the edge is the accepted report.
  always @(negedge clock) begin
    if (det_reset)    dr++;
    if (det_reset_nf) dr_nf++;
    if (!reset && rep_valid && rep_ready) begin
      acc++;
      check("sb_entry", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_m = sb.pop_front();
        check("report", 32'({rep_channel, rep_severity}), 32'({exp_m.ch, exp_m.sev}));
      end
    end
    if (!reset && rep_valid_nf && rep_ready_nf) begin
      acc_nf++;
      check("sb_nf_entry", 32'(sb_nf.size() != 0), 1);
      if (sb_nf.size() != 0) begin
        exp_nf = sb_nf.pop_front();
        check("report_nf", 32'({rep_channel_nf, rep_severity_nf}), 32'({exp_nf.ch, exp_nf.sev}));
      end
    end
  end

  initial begin
    reset = 1'b1; warning = '0; error = '0; mask = '0; rep_ready = 1'b0;
    error_nf = '0; rep_ready_nf = 1'b0;
    tick(3);
    check("rst_valid",     32'(rep_valid), 0);
    check("rst_channel",   32'(rep_channel), 0);
    check("rst_severity",  32'(rep_severity), 0);
    check("rst_det_reset", 32'(det_reset), 0);
    check("rst_err_count", 32'(err_count), 0);
    reset = 1'b0;
    tick(2);

    // Single sustained warning: one report, two cycles after the rise.
    rep_ready = 1'b1; a0 = acc; d0 = dr;
    sb.push_back(rep_t'{ch: 3'd3, sev: SEV_WARN});
    warning[3] = 1'b1;
    tick();
    check("t1_valid_early", 32'(rep_valid), 0);
    tick();
    check("t1_valid",    32'(rep_valid), 1);
    check("t1_channel",  32'(rep_channel), 3);
    check("t1_severity", 32'(rep_severity), 0);
    tick(20);
    check("t1_offers",    32'(acc - a0), 1);
    check("t1_det_reset", 32'(dr - d0), 0);
    warning[3] = 1'b0;
    tick(2);

    // Error outranks a same-cycle warning, then a 4-cycle flush.
    d0 = dr;
    sb.push_back(rep_t'{ch: 3'd5, sev: SEV_ERR});
    sb.push_back(rep_t'{ch: 3'd1, sev: SEV_WARN});
    warning[1] = 1'b1; error[5] = 1'b1;
    tick(2);
    check("t2_valid",    32'(rep_valid), 1);
    check("t2_channel",  32'(rep_channel), 5);
    check("t2_severity", 32'(rep_severity), 1);
    tick();
    check("t2_flush_on", 32'(det_reset), 1);
    check("t2_valid_lo", 32'(rep_valid), 0);
    drain(1'b0, "t2_drain");
    check("t2_flush_len", 32'(dr - d0), 4);
    check("t2_err_count", 32'(err_count), 1);
    warning[1] = 1'b0; error[5] = 1'b0;
    tick(2);

    // Round-robin order on the no-flush instance, including wrap from last=7.
    rep_ready_nf = 1'b1;
    sb_nf.push_back(rep_t'{ch: 3'd0, sev: SEV_ERR});
    sb_nf.push_back(rep_t'{ch: 3'd2, sev: SEV_ERR});
    sb_nf.push_back(rep_t'{ch: 3'd7, sev: SEV_ERR});
    error_nf = 8'b1000_0101;
    drain(1'b1, "t3_drain_a");
    error_nf = '0;
    tick();
    sb_nf.push_back(rep_t'{ch: 3'd0, sev: SEV_ERR});
    sb_nf.push_back(rep_t'{ch: 3'd2, sev: SEV_ERR});
    error_nf = 8'b0000_0101;
    drain(1'b1, "t3_drain_b");
    check("t3_err_count", 32'(err_count_nf), 5);
    check("t3_no_flush",  32'(dr_nf), 0);
    error_nf = '0;
    tick(2);

    // Backpressure: offer held stable, masking mid-stall does not withdraw it.
    rep_ready = 1'b0;
    sb.push_back(rep_t'{ch: 3'd4, sev: SEV_ERR});
    error[4] = 1'b1;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) mask[4] = 1'b1;
      tick();
      check("t4_stall_valid",    32'(rep_valid), 1);
      check("t4_stall_channel",  32'(rep_channel), 4);
      check("t4_stall_severity", 32'(rep_severity), 1);
    end
    rep_ready = 1'b1;
    drain(1'b0, "t4_drain");
    check("t4_err_count", 32'(err_count), 2);
    tick(6);
    mask[4] = 1'b0; error[4] = 1'b0;
    tick(2);

    // Masked edge is dropped.
    a0 = acc;
    mask[6] = 1'b1; error[6] = 1'b1;
    tick(10);
    check("t5_masked_offers", 32'(acc - a0), 0);
    check("t5_masked_valid",  32'(rep_valid), 0);
    error[6] = 1'b0;
    tick();
    mask[6] = 1'b0;
    tick(2);

    // New edge in the acceptance cycle wins over the clear.
    rep_ready = 1'b0; a0 = acc;
    sb.push_back(rep_t'{ch: 3'd2, sev: SEV_WARN});
    sb.push_back(rep_t'{ch: 3'd2, sev: SEV_WARN});
    warning[2] = 1'b1;
    tick(2);
    check("t5_offer_valid",   32'(rep_valid), 1);
    check("t5_offer_channel", 32'(rep_channel), 2);
    warning[2] = 1'b0;
    tick();
    warning[2] = 1'b1; rep_ready = 1'b1;
    tick();
    drain(1'b0, "t5_drain");
    check("t5_reoffer_count", 32'(acc - a0), 2);
    warning[2] = 1'b0;
    tick(2);

    // Reset during FLUSH aborts everything.
    sb.push_back(rep_t'{ch: 3'd0, sev: SEV_ERR});
    error[0] = 1'b1;
    tick(3);
    check("t6_in_flush",   32'(det_reset), 1);
    check("t6_err_before", 32'(err_count), 3);
    reset = 1'b1; error[0] = 1'b0;
    tick();
    check("t6_valid",     32'(rep_valid), 0);
    check("t6_channel",   32'(rep_channel), 0);
    check("t6_severity",  32'(rep_severity), 0);
    check("t6_det_reset", 32'(det_reset), 0);
    check("t6_err_count", 32'(err_count), 0);
    reset = 1'b0;
    tick(3);
    check("t6_idle_after", 32'(rep_valid), 0);

    // Saturation: 300 accepted errors on the no-flush instance.
    for (int i = 0; i < 300; i++) begin
      sb_nf.push_back(rep_t'{ch: 3'd1, sev: SEV_ERR});
      error_nf[1] = 1'b1;
      tick();
      error_nf[1] = 1'b0;
      tick(3);
      if (i == 253) check("t7_count_254", 32'(err_count_nf), 254);
      if (i == 254) check("t7_count_255", 32'(err_count_nf), 255);
    end
    drain(1'b1, "t7_drain");
    check("t7_saturated", 32'(err_count_nf), 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

Services the per-channel warning/error flags produced by the 8-channel error detector bank. It latches each new flag, ranks errors above warnings, and presents one report at a time on a single valid/ready report port, rotating round-robin between channels. After an accepted error report it optionally sequences a timed reset of the detector bank. It sits between the detector bank and the single downstream alarm/report consumer.

## Interface
- `h`, 8 — number of detector channels; minimum 2.
- `FLUSH_CYC`, 4 — number of cycles `det_reset` is held after an accepted error report; minimum 1.
- `AUTO_FLUSH`, 1 — 1 = run the FLUSH sequence after each accepted error report; 0 = never assert `det_reset`.
- `clock` in 1 — single clock; all logic acts on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `warning` in h — warning levels from the detector bank.
- `error` in h — error levels from the detector bank.
- `mask` in h — 1 = channel ignored.
- `rep_valid` out 1 — a report is offered.
- `rep_ready` in 1 — the consumer accepts the offered report.
- `rep_channel` out $clog2(h) — channel index of the offered report.
- `rep_severity` out 1 — 1 = error, 0 = warning.
- `det_reset` out 1 — reset request to the detector bank.
- `err_count` out 8 — count of accepted error reports; saturates at 255.

## Operation
- **Edge capture.**
  - Registered copies of `warning` and `error` are kept.
  - A rising edge on an unmasked channel (sampled 1, previous sample 0) sets that channel's pending bit: `pw[i]` for warnings, `pe[i]` for errors.
  - A sustained level is reported once only.
- **Mask.**
  - While `mask[i]=1`, edges on channel i are dropped and `pw[i]`/`pe[i]` are cleared.
  - A report already on offer is not withdrawn when its channel becomes masked.
- **FSM states:** IDLE, OFFER, FLUSH.
  - **IDLE.** If any `pe` bit is set, pick among `pe`; otherwise, if any `pw` bit is set, pick among `pw`. Register the channel and severity, then go to OFFER. With nothing pending, stay in IDLE.
  - **OFFER.** `rep_valid=1`. `rep_channel` and `rep_severity` are held stable until `rep_valid & rep_ready`. On acceptance:
    - Clear the pending bit of the offered severity for that channel.
    - An error acceptance also clears `pw` for that channel.
    - Update the round-robin pointer to this channel.
    - Go to FLUSH if severity is error and `AUTO_FLUSH=1`; otherwise go to IDLE.
  - **FLUSH.** `det_reset=1` for exactly `FLUSH_CYC` cycles, counted by an internal down-counter, then IDLE. Edge capture keeps running in FLUSH; pending bits survive.
- **Round-robin.** One pointer `last`, shared by both severities, reset value h-1. The search starts at `last+1` and wraps modulo h.
- **err_count.** Increments on every accepted error report; holds at 255.
- **Simultaneous set and clear** of the same pending bit in one cycle: the set wins, because the new edge is a new event.

## Timing
- **Reset values.**
  - Outputs: `rep_valid=0`, `rep_channel=0`, `rep_severity=0`, `det_reset=0`, `err_count=0`.
  - Internal: state=IDLE, all pending bits 0, edge registers 0, `last`=h-1.
- **Reset asserted mid-OFFER or mid-FLUSH** aborts at the next edge with the values above. The offered report is lost.
- **Latency.** An edge sampled at clock k sets the pending bit after k. The pick happens at k+1, so `rep_valid` is high after k+1 (2 cycles), given state IDLE.
- **Acceptance at edge m.**
  - `rep_valid` is low after m.
  - If flushing, `det_reset` is high for cycles m+1 .. m+FLUSH_CYC; IDLE is re-entered after m+FLUSH_CYC.
- **Throughput.** Best case is one report per 2 cycles: one mandatory IDLE cycle between offers.
- **Ready without valid** is ignored. `rep_ready` may be held high permanently.

## Structure
- **Package `alarm_pkg`:**
  - State enum IDLE/OFFER/FLUSH.
  - Severity constants `SEV_WARN=0` and `SEV_ERR=1`.
  - Count saturation constant 255.
- **Sub-module `rr_pick`:** parameterised by h. It takes a request vector and a start pointer and returns `found` plus an index. It is combinational and instantiated twice, once for `pe` and once for `pw`. The scheduler holds all state.

## Test plan
- **Single warning:** reset, then raise `warning[3]` and hold it high for 20 cycles → exactly one offer, `rep_channel=3`, `rep_severity=0`, `rep_valid` 2 cycles after the rise; `det_reset` never asserted.
- **Error priority and flush:** raise `warning[1]` and `error[5]` in the same cycle, `rep_ready=1` → the first report is ch5/err and `det_reset` is high for 4 cycles; then ch1/warn; `err_count=1`.
- **Round-robin:** raise `error[0]`, `error[2]` and `error[7]` together, `AUTO_FLUSH=0`, `rep_ready=1` → order 0, 2, 7. Then re-edge `error[0]` and `error[2]` → order 0, 2 (wrap from `last`=7).
- **Backpressure:** `rep_ready=0` for 10 cycles while offering ch4/err → `rep_valid`, channel and severity stay constant; raising `mask[4]` during the stall does not withdraw the offer; acceptance after `rep_ready=1`.
- **Mask and set/clear collision:** `mask[6]=1` with a rising `error[6]` → no report. Separately, a new `warning[2]` edge in the same cycle as acceptance of ch2/warn → ch2/warn is offered again.
- **Reset and saturation:** assert `reset` during FLUSH → all outputs go to reset values next cycle. Generate 300 accepted errors → `err_count=255`.
